whirlpool_mu_stream: RTL and testbench

Streaming successor to the Whirlpool W-cipher mu mapping. The block accepts a 512-bit message block as a sequence of WORD_W-bit words over a valid/ready handshake. It assembles the words into the 8x8 byte state matrix and presents the complete block on a registered 512-bit bus with its own valid/ready handshake. It sits between the message/padding front end and the hash engine's W-cipher input, and optionally double-buffers so the front end can stream at full rate while the engine holds the previous block.

---
 rtl/whirlpool_pkg.sv | 27 ++
 rtl/whirlpool_mu_fill.sv | 73 +++++++
 rtl/whirlpool_mu_stream.sv | 91 +++++++++
 tb/tb_whirlpool_mu_stream.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/whirlpool_pkg.sv
// Shared constants and helpers for the Whirlpool mu-mapping stream blocks.
// Holds the state geometry, the fill-buffer state type, the byte-offset
// helper for B[i][j] and the legal input-word-width check.
package whirlpool_pkg;

  localparam int unsigned STATE_W = 512;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned ROWS    = 8;
  localparam int unsigned COLS    = 8;

  typedef enum logic [1:0] {
    FILL_EMPTY,
    FILL_PARTIAL,
    FILL_FULL
  } fill_state_e;

  // Bit offset of byte B[i][j] within the row-major 512-bit state.
  function automatic int unsigned byte_offset(int unsigned i, int unsigned j);
    return (i % ROWS) * COLS * BYTE_W + (j % COLS) * BYTE_W;
  endfunction

  function automatic bit legal_word_w(int unsigned w);
    return (w == 8) || (w == 16) || (w == 32) || (w == 64) ||
           (w == 128) || (w == 256) || (w == 512);
  endfunction

endpackage

// File: rtl/whirlpool_mu_fill.sv
// Indexed word accumulator for the mu mapping.
// Ports:
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_write        : store i_word at slot o_count and advance
//   i_word         : input word, bit 0 is leftmost
//   i_clear        : discard the partial block
//   i_flush        : block handed downstream, return to empty
//   o_count        : words held
//   o_full         : N words held, waiting for transfer
//   o_block        : held words with i_word merged into the next free slot
module whirlpool_mu_fill
  import whirlpool_pkg::*;
#(
  parameter  int unsigned WORD_W = 64,
  localparam int unsigned N      = STATE_W / WORD_W,
  localparam int unsigned CW     = $clog2(N) + 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_write,
  input  logic [0:WORD_W-1]   i_word,
  input  logic                i_clear,
  input  logic                i_flush,
  output logic [CW-1:0]       o_count,
  output logic                o_full,
  output logic [0:STATE_W-1]  o_block
);

  localparam logic [CW-1:0] N_C = CW'(N);

  logic [CW-1:0]      r_count;
  logic [0:STATE_W-1] r_buf;
  int unsigned        w_idx;
  fill_state_e        w_state;
  logic [0:STATE_W-1] w_block;

  always_comb begin
    w_idx = 32'(r_count);
    if (r_count == '0)
      w_state = FILL_EMPTY;
    else if (r_count == N_C)
      w_state = FILL_FULL;
    else
      w_state = FILL_PARTIAL;
  end

  // The final word is merged combinationally so a completing block can be
  // handed downstream on the same edge that accepts its last word.
  always_comb begin
    w_block = r_buf;
    if (w_state != FILL_FULL)
      w_block[w_idx*WORD_W +: WORD_W] = i_word;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
      r_buf   <= '0;
    end else begin
      if (i_clear || i_flush)
        r_count <= '0;
      else if (i_write)
        r_count <= r_count + CW'(1);
      if (i_write)
        r_buf[w_idx*WORD_W +: WORD_W] <= i_word;
    end
  end

  assign o_count = r_count;
  assign o_full  = (w_state == FILL_FULL);
  assign o_block = w_block;

endmodule

// File: rtl/whirlpool_mu_stream.sv
// Streaming Whirlpool mu mapping: assembles N = 512/WORD_W input words into
// the 8x8 byte state and presents it on a registered 512-bit bus.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   clear                : synchronous discard of a partial fill block
//   in_valid/in_ready    : input word handshake, in_word bit 0 leftmost
//   out_valid/out_ready  : output block handshake, out_state row-major
//   fill_count           : words held in the fill buffer
module whirlpool_mu_stream
  import whirlpool_pkg::*;
#(
  parameter  int unsigned WORD_W = 64,
  parameter  int unsigned DEPTH  = 2,
  localparam int unsigned N      = STATE_W / WORD_W,
  localparam int unsigned CW     = $clog2(N) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [0:WORD_W-1]   in_word,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [0:STATE_W-1]  out_state,
  output logic [CW-1:0]       fill_count
);

  if (!legal_word_w(WORD_W) || !(DEPTH == 1 || DEPTH == 2)) begin : g_bad_param
    $error("whirlpool_mu_stream: illegal WORD_W or DEPTH");
  end

  localparam logic [CW-1:0] LAST_C = CW'(N - 1);

  logic               r_out_valid;
  logic [0:STATE_W-1] r_out_state;

  logic [CW-1:0]      w_count;
  logic               w_full;
  logic [0:STATE_W-1] w_block;
  logic               w_space;
  logic               w_accept;
  logic               w_last;
  logic               w_out_free;
  logic               w_xfer;
  logic               w_fill_clear;

  // Single-buffer mode reuses the fill buffer as a staging area and hands the
  // block over on the last-word edge; blocking input while out_valid is high
  // keeps the observable behaviour of accumulating in the output register.
  always_comb begin
    w_space      = !w_full && ((DEPTH == 1) ? !r_out_valid : 1'b1);
    in_ready     = !reset && !clear && w_space;
    w_accept     = in_valid && in_ready;
    w_last       = w_accept && (w_count == LAST_C);
    w_out_free   = !r_out_valid || out_ready;
    w_xfer       = (w_last || w_full) && w_out_free;
    w_fill_clear = clear && !w_full;
  end

  whirlpool_mu_fill #(
    .WORD_W (WORD_W)
  ) u_fill (
    .i_clk   (clk),
    .i_reset (reset),
    .i_write (w_accept),
    .i_word  (in_word),
    .i_clear (w_fill_clear),
    .i_flush (w_xfer),
    .o_count (w_count),
    .o_full  (w_full),
    .o_block (w_block)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_state <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_state <= w_block;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_state  = r_out_state;
  assign fill_count = w_count;

endmodule

// File: tb/tb_whirlpool_mu_stream.sv
module tb_whirlpool_mu_stream;

  localparam int NC = 5;
  localparam int CFG_W [NC] = '{64, 64, 8, 32, 512};
  localparam int CFG_D [NC] = '{2, 1, 2, 2, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic         s_in_valid  [NC];
  logic         s_clear     [NC];
  logic         s_out_ready [NC];
  logic [0:511] s_in_word   [NC];

  logic         d_in_ready  [NC];
  logic         d_out_valid [NC];
  logic [0:511] d_out_state [NC];
  logic [7:0]   d_fill      [NC];

  for (genvar g = 0; g < NC; g++) begin : g_dut
    localparam int unsigned WW = CFG_W[g];
    localparam int unsigned DD = CFG_D[g];
    localparam int unsigned NN = 512 / WW;
    localparam int unsigned CC = $clog2(NN) + 1;
    logic          w_rdy;
    logic          w_ov;
    logic [0:511]  w_os;
    logic [CC-1:0] w_fc;
    whirlpool_mu_stream #(.WORD_W(WW), .DEPTH(DD)) u_dut (
      .clk        (clk),
      .reset      (rst),
      .clear      (s_clear[g]),
      .in_valid   (s_in_valid[g]),
      .in_ready   (w_rdy),
      .in_word    (s_in_word[g][0:WW-1]),
      .out_valid  (w_ov),
      .out_ready  (s_out_ready[g]),
      .out_state  (w_os),
      .fill_count (w_fc)
    );
    assign d_in_ready[g]  = w_rdy;
    assign d_out_valid[g] = w_ov;
    assign d_out_state[g] = w_os;
    assign d_fill[g]      = 8'(w_fc);
  end

  // Behavioural model: words are shifted into place by count, blocks move
  // as a whole when the output slot is free.
  int           m_cnt   [NC];
  logic [0:511] m_blk   [NC];
  logic [0:511] m_out   [NC];
  logic         m_valid [NC];
  logic         m_acc   [NC];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int pulses[$];

  function automatic int nwords(int k);
    return 512 / CFG_W[k];
  endfunction

  function automatic logic [0:511] wmask(int k);
    logic [0:511] ones = '1;
    return ~(ones >> CFG_W[k]);
  endfunction

  function automatic logic exp_ready(int k);
    return !rst && !s_clear[k] && (m_cnt[k] < nwords(k)) &&
           (CFG_D[k] == 2 || !m_valid[k]);
  endfunction

  function automatic logic [0:511] mkword(int first, int nbytes);
    logic [0:511] w = '0;
    for (int b = 0; b < nbytes; b++) w[8*b +: 8] = 8'(first + b);
    return w;
  endfunction

  function automatic logic [0:511] mkrep(int v, int nbytes);
    logic [0:511] w = '0;
    for (int b = 0; b < nbytes; b++) w[8*b +: 8] = 8'(v);
    return w;
  endfunction

  function automatic logic [7:0] byte_of(logic [0:511] s, int i, int j);
    logic [0:7] t;
    t = s[64*i + 8*j +: 8];
    return t;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      m_cnt[k] = 0; m_blk[k] = '0; m_out[k] = '0; m_valid[k] = 1'b0; m_acc[k] = 1'b0;
    end
  endtask

  task automatic model_step(int k);
    logic rdy;
    logic drain;
    rdy      = exp_ready(k);
    drain    = m_valid[k] && s_out_ready[k];
    m_acc[k] = 1'b0;
    if (rst) begin
      m_cnt[k] = 0; m_blk[k] = '0; m_out[k] = '0; m_valid[k] = 1'b0;
      return;
    end
    if (s_in_valid[k] && rdy) begin
      m_blk[k] = m_blk[k] | ((s_in_word[k] & wmask(k)) >> (m_cnt[k] * CFG_W[k]));
      m_cnt[k] = m_cnt[k] + 1;
      m_acc[k] = 1'b1;
    end else if (s_clear[k] && m_cnt[k] < nwords(k)) begin
      m_cnt[k] = 0; m_blk[k] = '0;
    end
    if (m_cnt[k] == nwords(k) && (!m_valid[k] || drain)) begin
      m_out[k] = m_blk[k]; m_valid[k] = 1'b1; m_cnt[k] = 0; m_blk[k] = '0;
    end else if (drain) begin
      m_valid[k] = 1'b0;
    end
  endtask

  task automatic check(string name, logic [0:511] act, logic [0:511] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NC; k++) begin
      check($sformatf("cfg%0d in_ready", k),   512'(d_in_ready[k]),  512'(exp_ready(k)));
      check($sformatf("cfg%0d out_valid", k),  512'(d_out_valid[k]), 512'(m_valid[k]));
      check($sformatf("cfg%0d out_state", k),  d_out_state[k],        m_out[k]);
      check($sformatf("cfg%0d fill_count", k), 512'(d_fill[k]),      512'(m_cnt[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < NC; k++) model_step(k);
    cyc++;
    @(negedge clk);
    compare_all();
    if (d_out_valid[1]) pulses.push_back(cyc);
  endtask

  task automatic send(int k, logic [0:511] w);
    logic got = 1'b0;
    s_in_valid[k] = 1'b1;
    s_in_word[k]  = w;
    for (int t = 0; t < 40 && !got; t++) begin
      tick();
      got = m_acc[k];
    end
    check($sformatf("cfg%0d word accepted in budget", k), 512'(got), 512'(1));
  endtask

  task automatic idle_all();
    for (int k = 0; k < NC; k++) begin
      s_in_valid[k] = 1'b0; s_clear[k] = 1'b0; s_out_ready[k] = 1'b1; s_in_word[k] = '0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t8;
    logic [0:511] w;
    idle_all();
    model_reset();
    rst = 1'b1;
    repeat (3) tick();
    check("reset out_valid", 512'(d_out_valid[0]), 512'(0));
    check("reset in_ready",  512'(d_in_ready[0]),  512'(0));
    rst = 1'b0;
    #1;
    check("in_ready after reset release", 512'(d_in_ready[0]), 512'(1));

    // 64-bit words, double buffered, consumer always ready
    for (int i = 0; i < 8; i++) send(0, mkword(8*i, 8));
    s_in_valid[0] = 1'b0;
    check("t1 out_valid",  512'(d_out_valid[0]), 512'(1));
    check("t1 B00", 512'(byte_of(d_out_state[0], 0, 0)), 512'(8'h00));
    check("t1 B07", 512'(byte_of(d_out_state[0], 0, 7)), 512'(8'h07));
    check("t1 B10", 512'(byte_of(d_out_state[0], 1, 0)), 512'(8'h08));
    check("t1 B77", 512'(byte_of(d_out_state[0], 7, 7)), 512'(8'h3F));
    tick();
    check("t1 out_valid one cycle", 512'(d_out_valid[0]), 512'(0));

    // consumer stalled: second block waits in the fill buffer
    s_out_ready[0] = 1'b0;
    for (int i = 0; i < 16; i++) send(0, mkword(8*i, 8));
    s_in_valid[0] = 1'b0;
    check("t2 in_ready low when full", 512'(d_in_ready[0]), 512'(0));
    check("t2 fill_count full",        512'(d_fill[0]),     512'(8));
    check("t2 first block held B00",   512'(byte_of(d_out_state[0], 0, 0)), 512'(8'h00));
    s_out_ready[0] = 1'b1;
    tick();
    check("t2 out_valid stays", 512'(d_out_valid[0]), 512'(1));
    check("t2 B00 second",      512'(byte_of(d_out_state[0], 0, 0)), 512'(8'h40));
    check("t2 B77 second",      512'(byte_of(d_out_state[0], 7, 7)), 512'(8'h7F));
    check("t2 fill emptied",    512'(d_fill[0]), 512'(0));
    tick();

    // single buffer, back-to-back blocks
    pulses.delete();
    t8 = 0;
    for (int i = 0; i < 24; i++) begin
      send(1, mkword(8*i, 8));
      if (i == 7) t8 = cyc;
    end
    s_in_valid[1] = 1'b0;
    repeat (3) tick();
    check("t3 pulse count", 512'(pulses.size()), 512'(3));
    if (pulses.size() >= 3) begin
      check("t3 first latency", 512'(pulses[0]), 512'(t8));
      check("t3 spacing 1", 512'(pulses[1] - pulses[0]), 512'(9));
      check("t3 spacing 2", 512'(pulses[2] - pulses[1]), 512'(9));
    end

    // byte words with a clear in the middle
    for (int i = 0; i < 5; i++) send(2, mkword(8'h10 + i, 1));
    s_clear[2] = 1'b1;
    s_in_valid[2] = 1'b1;
    s_in_word[2] = mkword(8'h55, 1);
    tick();
    check("t4 clear fill_count", 512'(d_fill[2]), 512'(0));
    s_clear[2] = 1'b0;
    for (int i = 0; i < 64; i++) send(2, mkword(8'hA0 + i, 1));
    s_in_valid[2] = 1'b0;
    check("t4 out_valid", 512'(d_out_valid[2]), 512'(1));
    check("t4 B00", 512'(byte_of(d_out_state[2], 0, 0)), 512'(8'hA0));
    check("t4 B77", 512'(byte_of(d_out_state[2], 7, 7)), 512'(8'hDF));
    tick();

    // 32-bit words, asynchronous reset mid-block
    s_out_ready[3] = 1'b0;
    for (int i = 0; i < 16; i++) send(3, mkrep(8'h80 + i, 4));
    for (int i = 0; i < 7; i++)  send(3, mkrep(8'h20 + i, 4));
    s_in_valid[3] = 1'b0;
    check("t5 pre out_valid", 512'(d_out_valid[3]), 512'(1));
    check("t5 pre fill",      512'(d_fill[3]),      512'(7));
    #2 rst = 1'b1;
    #1;
    check("t5 async out_valid", 512'(d_out_valid[3]), 512'(0));
    check("t5 async out_state", d_out_state[3],        '0);
    check("t5 async fill",      512'(d_fill[3]),      512'(0));
    check("t5 async in_ready",  512'(d_in_ready[3]),  512'(0));
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("t5 in_ready after release", 512'(d_in_ready[3]), 512'(1));
    s_out_ready[3] = 1'b1;
    for (int i = 0; i < 16; i++) send(3, mkrep(i, 4));
    s_in_valid[3] = 1'b0;
    check("t5 clean out_valid", 512'(d_out_valid[3]), 512'(1));
    check("t5 clean B00", 512'(byte_of(d_out_state[3], 0, 0)), 512'(8'h00));
    check("t5 clean B40", 512'(byte_of(d_out_state[3], 4, 0)), 512'(8'h08));
    check("t5 clean B77", 512'(byte_of(d_out_state[3], 7, 7)), 512'(8'h0F));
    tick();

    // single 512-bit word is a whole block
    w = mkword(0, 64);
    send(4, w);
    s_in_valid[4] = 1'b0;
    check("t6 out_valid",  512'(d_out_valid[4]), 512'(1));
    check("t6 out_state",  d_out_state[4], w);
    check("t6 B77", 512'(byte_of(d_out_state[4], 7, 7)), 512'(8'h3F));
    tick();

    // randomized traffic on every configuration
    for (int it = 0; it < 3000; it++) begin
      for (int k = 0; k < NC; k++) begin
        for (int i = 0; i < 16; i++) w[32*i +: 32] = $urandom;
        s_in_word[k]   = w & wmask(k);
        s_in_valid[k]  = ($urandom % 4) != 0;
        s_out_ready[k] = ($urandom % 2) != 0;
        s_clear[k]     = ($urandom % 32) == 0;
      end
      rst = (it == 1500);
      tick();
    end
    rst = 1'b0;
    idle_all();
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
